// File: rtl/reg_dump_unit.sv
// Register-file dump engine: walks REG_MAX words out over a valid/ready stream.
// Optional macro REG_DUMP_CHECKSUM_EN appends an XOR checksum word at index REG_MAX.
module reg_dump_unit #(
    parameter int REG_MAX  = 32,
    parameter int REG_SIZE = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [4:0]          rf_rd_addr,
    input  logic [REG_SIZE-1:0] rf_rd_data,
    output logic [REG_SIZE-1:0] out_data,
    output logic [5:0]          out_idx,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done
);

`ifdef REG_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        SEND = 3'd2,
        DONE = 3'd3,
        CHK  = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        SEND = 3'd2,
        DONE = 3'd3
    } state_e;
`endif

    localparam logic [4:0] LAST_IDX = 5'(REG_MAX - 1);
`ifdef REG_DUMP_CHECKSUM_EN
    localparam logic [5:0] CHK_IDX  = 6'(REG_MAX);
`endif

    state_e              state_q, state_d;
    logic [4:0]          idx_q, idx_d;
    logic [REG_SIZE-1:0] out_data_q, out_data_d;
    logic [5:0]          out_idx_q, out_idx_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [REG_SIZE-1:0] chk_q, chk_d;
`endif

    // Next-state, index, data capture and (optional) checksum accumulation.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
`ifdef REG_DUMP_CHECKSUM_EN
        chk_d      = chk_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    idx_d   = 5'd0;
`ifdef REG_DUMP_CHECKSUM_EN
                    chk_d   = {REG_SIZE{1'b0}};
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                out_data_d = rf_rd_data;
                out_idx_d  = {1'b0, idx_q};
                state_d    = SEND;
            end
            SEND: begin
                if (out_ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
                    chk_d = chk_q ^ out_data_q;
`endif
                    if (idx_q < LAST_IDX) begin
                        idx_d   = idx_q + 5'd1;
                        state_d = READ;
                    end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                        // Checksum word is preloaded so CHK offers it immediately.
                        out_data_d = chk_q ^ out_data_q;
                        out_idx_d  = CHK_IDX;
                        state_d    = CHK;
`else
                        state_d    = DONE;
`endif
                    end
                end else begin
                    state_d = SEND;
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            CHK: begin
                if (out_ready) begin
                    state_d = DONE;
                end else begin
                    state_d = CHK;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
                idx_d   = 5'd0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = 5'd0;
            end
        endcase

        // Status outputs are registered from the next state so they align with it.
`ifdef REG_DUMP_CHECKSUM_EN
        out_valid_d = (state_d == SEND) || (state_d == CHK);
`else
        out_valid_d = (state_d == SEND);
`endif
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 5'd0;
            out_data_q  <= {REG_SIZE{1'b0}};
            out_idx_q   <= 6'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            chk_q       <= {REG_SIZE{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef REG_DUMP_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
        end
    end

    assign rf_rd_addr = idx_q;
    assign out_data   = out_data_q;
    assign out_idx    = out_idx_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/reg_dump_unit.md
REG_DUMP_UNIT -- requirements
Module: reg_dump_unit

Interface
REQ-001 Parameter REG_MAX, default 32, number of register-file words to dump.
REQ-002 Parameter REG_SIZE, default 32, bit width of each register word.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a dump; sampled only in IDLE.
REQ-006 rf_rd_addr  output  5  register-file read address, index of the word being fetched.
REQ-007 rf_rd_data  input  REG_SIZE  combinational register-file read data for rf_rd_addr, valid in the same cycle.
REQ-008 out_data  output  REG_SIZE  dumped word.
REQ-009 out_idx  output  6  index of the word on out_data (0..REG_MAX-1; REG_MAX for the checksum word).
REQ-010 out_valid  output  1  out_data/out_idx hold a word to transfer.
REQ-011 out_ready  input  1  consumer accepts the word; a transfer occurs on a cycle with out_valid && out_ready.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  single-cycle pulse after the final transfer.

Function
REQ-014 FSM states SHALL be IDLE, READ, SEND, CHK, DONE.
REQ-015 IDLE: start=1 -> READ with idx=0; start=0 -> stay in IDLE.
REQ-016 READ (one cycle): rf_rd_addr=idx; rf_rd_data registered into out_data, idx into out_idx; -> SEND.
REQ-017 SEND: out_valid=1; on transfer, idx<REG_MAX-1 -> idx+1 and READ; idx=REG_MAX-1 -> CHK (macro defined) or DONE (macro undefined).
REQ-018 out_data and out_idx SHALL remain stable while out_valid=1 and out_ready=0, for any stall length.
REQ-019 Throughput: one word per 2 cycles with out_ready held high; first out_valid 2 cycles after the start-sampling edge.
REQ-020 DONE: done=1 for exactly one cycle, out_valid=0; -> IDLE.
REQ-021 start asserted in any state other than IDLE SHALL be ignored; dump never restarts mid-sequence.
REQ-022 idx SHALL never exceed REG_MAX-1 and SHALL not wrap; exactly REG_MAX data words are emitted per dump.
REQ-023 rf_rd_addr SHALL equal idx in all states (0 in IDLE).
REQ-024 out_valid SHALL be 0 in IDLE, READ and DONE.
REQ-025 The block SHALL never write the register file.

Reset
REQ-026 rst=1 at a posedge SHALL force IDLE, idx=0, out_data=0, out_idx=0, out_valid=0, busy=0, done=0, checksum=0, regardless of state.
REQ-027 Reset mid-dump SHALL abandon the sequence; no further words are offered; the next start begins again at index 0.
REQ-028 rst has priority over start on the same edge.

Configuration
REQ-029 Macro REG_DUMP_CHECKSUM_EN defined: a REG_SIZE-bit XOR accumulator SHALL clear on leaving IDLE and fold in each transferred data word; CHK state SHALL offer out_data=accumulator, out_idx=REG_MAX, out_valid=1 with the same stall rules, -> DONE on transfer.
REQ-030 Macro REG_DUMP_CHECKSUM_EN undefined: no accumulator or CHK state; SEND -> DONE after word REG_MAX-1; out_idx never equals REG_MAX.

Verification
REQ-031 R[i]=i*0x11111111 (mod 2^32), out_ready=1, pulse start -> 32 words, out_idx 0..31, out_data match R[i], done pulse 1 cycle after last transfer, total 64 data cycles.
REQ-032 Same image, out_ready toggled 1-cycle-on/2-off pseudo-randomly -> identical word sequence; out_data stable across every stall cycle.
REQ-033 rst asserted when out_idx=10 with out_valid=1 -> next cycle out_valid=0, busy=0; new start emits from out_idx=0.
REQ-034 start held high through a whole dump -> exactly one dump of 32 words, then a new dump starts only after DONE->IDLE.
REQ-035 With REG_DUMP_CHECKSUM_EN, all R[i]=0xA5A5A5A5 -> 33rd word out_idx=32, out_data=0x00000000; R[0]=0x1, others 0 -> checksum 0x00000001.
REQ-036 Without REG_DUMP_CHECKSUM_EN -> exactly 32 transfers, out_idx never 32, done follows word 31.
